// File: rtl/noise_lfsr_multi.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// noise_lfsr_multi
//   SN76489-family noise channel with a runtime-selectable LFSR variant
//   (BBC/SG-1000, SMS/Genesis, Tandy). A half-rate phase flip-flop makes the
//   LFSR shift on every second divider wrap. In NF=11 the phase is clocked by
//   tone channel 3 wrap pulses instead of the private divider.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   divider tick enable (master/16 strobe)
//   ctrl_we      in   1   write strobe for the noise control register
//   ctrl         in   3   {FB, NF1, NF0}
//   tap_mode     in   2   0=BBC, 1=SMS, 2=Tandy, 3=reserved (behaves as BBC)
//   tone3_wrap   in   1   one-cycle pulse per tone channel 3 wrap
//   out          out  1   noise bit (lfsr[0])
//   shift_strobe out  1   high in the cycle a new LFSR value is visible
//   lfsr_state   out  16  LFSR contents; bit 15 is 0 in 15-bit modes
// ---------------------------------------------------------------------------
module noise_lfsr_multi #(
    parameter int unsigned COUNTER_BITS = 10,
    parameter int unsigned N0           = 16,
    parameter int unsigned N1           = 32,
    parameter int unsigned N2           = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        ctrl_we,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  tap_mode,
    input  logic        tone3_wrap,
    output logic        out,
    output logic        shift_strobe,
    output logic [15:0] lfsr_state
);

    typedef enum logic [1:0] {
        TAP_BBC   = 2'd0,
        TAP_SMS   = 2'd1,
        TAP_TANDY = 2'd2,
        TAP_RSVD  = 2'd3
    } tap_e;

    typedef enum logic [1:0] {
        NF_N0    = 2'd0,
        NF_N1    = 2'd1,
        NF_N2    = 2'd2,
        NF_TONE3 = 2'd3
    } nf_e;

    // Seed is a single 1 in the top bit of the active register width.
    function automatic logic [15:0] seed_of(input tap_e t);
        return (t == TAP_SMS) ? 16'h8000 : 16'h4000;
    endfunction

    // Counter reload value; NF=11 never counts, so its value is irrelevant.
    function automatic logic [COUNTER_BITS-1:0] reload_of(input nf_e nf);
        logic [COUNTER_BITS-1:0] v;
        case (nf)
            NF_N1:   v = COUNTER_BITS'(N1 - 1);
            NF_N2:   v = COUNTER_BITS'(N2 - 1);
            default: v = COUNTER_BITS'(N0 - 1);
        endcase
        return v;
    endfunction

    logic [2:0]              r_ctrl;
    tap_e                    r_tap;
    logic                    r_phase;
    logic [COUNTER_BITS-1:0] r_counter;
    logic [15:0]             r_lfsr;
    logic                    r_strobe;

    nf_e         w_nf;
    logic        w_white;
    logic        w_tone3;
    logic        w_wrap;
    logic        w_toggle;
    logic        w_shift;
    logic        w_tap_bit;
    logic        w_in_bit;
    logic [15:0] w_lfsr_shift;
    logic [15:0] w_lfsr_next;

    assign w_nf    = nf_e'(r_ctrl[1:0]);
    assign w_white = r_ctrl[2];
    assign w_tone3 = (w_nf == NF_TONE3);
    assign w_wrap  = en && (r_counter == '0);

    // Phase source: tone3 pulses in NF=11, divider wraps otherwise.
    assign w_toggle = w_tone3 ? tone3_wrap : w_wrap;
    // Only the 0->1 phase edge shifts, halving the toggle rate.
    assign w_shift  = w_toggle && !r_phase;

    always_comb begin
        w_tap_bit = r_lfsr[1];
        case (r_tap)
            TAP_SMS:   w_tap_bit = r_lfsr[3];
            TAP_TANDY: w_tap_bit = r_lfsr[4];
            default:   w_tap_bit = r_lfsr[1];
        endcase

        w_in_bit = w_white ? (r_lfsr[0] ^ w_tap_bit) : r_lfsr[0];

        if (r_tap == TAP_SMS) begin
            w_lfsr_shift = {w_in_bit, r_lfsr[15:1]};
        end else begin
            w_lfsr_shift = {1'b0, w_in_bit, r_lfsr[14:1]};
        end

        // An all-zero register would lock up the white generator; reseed it.
        if (w_white && (r_lfsr == '0)) begin
            w_lfsr_next = seed_of(r_tap);
        end else begin
            w_lfsr_next = w_lfsr_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= '0;
            r_tap     <= TAP_BBC;
            r_phase   <= 1'b0;
            r_counter <= COUNTER_BITS'(N0 - 1);
            r_lfsr    <= 16'h4000;
            r_strobe  <= 1'b0;
        end else if (ctrl_we) begin
            // A register write overrides any shift due in the same cycle.
            r_ctrl    <= ctrl;
            r_tap     <= tap_e'(tap_mode);
            r_phase   <= 1'b0;
            r_counter <= reload_of(nf_e'(ctrl[1:0]));
            r_lfsr    <= seed_of(tap_e'(tap_mode));
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= w_shift;
            if (w_toggle) begin
                r_phase <= ~r_phase;
            end
            if (!w_tone3 && en) begin
                if (r_counter == '0) begin
                    r_counter <= reload_of(w_nf);
                end else begin
                    r_counter <= r_counter - COUNTER_BITS'(1);
                end
            end
            if (w_shift) begin
                r_lfsr <= w_lfsr_next;
            end
        end
    end

    assign out          = r_lfsr[0];
    assign shift_strobe = r_strobe;
    assign lfsr_state   = r_lfsr;

endmodule

// File: tb/tb_noise_lfsr_multi.sv
`timescale 1ns/1ps
module tb_noise_lfsr_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ctrl_we = 1'b0;
    logic [2:0]  ctrl = 3'b000;
    logic [1:0]  tap_mode = 2'b00;
    logic        tone3_wrap = 1'b0;
    logic        out;
    logic        shift_strobe;
    logic [15:0] lfsr_state;

    noise_lfsr_multi #(
        .COUNTER_BITS(10),
        .N0(16),
        .N1(32),
        .N2(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .ctrl_we(ctrl_we),
        .ctrl(ctrl),
        .tap_mode(tap_mode),
        .tone3_wrap(tone3_wrap),
        .out(out),
        .shift_strobe(shift_strobe),
        .lfsr_state(lfsr_state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int unsigned edge_no;
        logic [15:0] lfsr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  c;
        logic [1:0]  t;
        int unsigned shifts;
        bit          gaps;
        logic [15:0] exp;
    } vec_t;

    // Reference model state
    logic [15:0] m_lfsr;
    logic        m_fb;
    logic [1:0]  m_tap;
    int unsigned m_n;
    int unsigned m_ticks;
    int unsigned m_wraps;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] seed(input logic [1:0] t);
        return (t == 2'd1) ? 16'h8000 : 16'h4000;
    endfunction

    function automatic int unsigned n_of(input logic [1:0] nf);
        case (nf)
            2'd1:    return 32'd32;
            2'd2:    return 32'd64;
            default: return 32'd16;
        endcase
    endfunction

    function automatic logic [15:0] model_next(input logic [15:0] s, input logic fb, input logic [1:0] t);
        int unsigned w;
        int unsigned tp;
        logic        b;
        logic [15:0] r;
        w  = (t == 2'd1) ? 32'd16 : 32'd15;
        tp = (t == 2'd1) ? 32'd3 : ((t == 2'd2) ? 32'd4 : 32'd1);
        if (fb && s == 16'h0) return seed(t);
        b = fb ? (s[0] ^ s[tp]) : s[0];
        r = s >> 1;
        r[w-1] = b;
        return r;
    endfunction

    task automatic push_shift();
        exp_t e;
        m_lfsr    = model_next(m_lfsr, m_fb, m_tap);
        e.edge_no = cyc + 1;
        e.lfsr    = m_lfsr;
        sb.push_back(e);
    endtask

    // Called at a falling edge; the write takes effect on the next rising edge.
    task automatic do_write(input logic [2:0] c, input logic [1:0] t);
        ctrl       = c;
        tap_mode   = t;
        ctrl_we    = 1'b1;
        en         = 1'b1;
        tone3_wrap = 1'($urandom_range(0, 1));
        m_lfsr  = seed(t);
        m_fb    = c[2];
        m_tap   = t;
        m_n     = n_of(c[1:0]);
        m_ticks = 0;
        m_wraps = 0;
        @(negedge clk);
        ctrl_we    = 1'b0;
        en         = 1'b0;
        tone3_wrap = 1'b0;
    endtask

    task automatic run_ticks(input int unsigned n, input bit gaps);
        int unsigned done;
        done = 0;
        while (done < n) begin
            en         = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tone3_wrap = ($urandom_range(0, 7) == 0);
            if (en) begin
                done++;
                m_ticks++;
                if (m_ticks % (2 * m_n) == m_n) push_shift();
            end
            @(negedge clk);
        end
        en         = 1'b0;
        tone3_wrap = 1'b0;
    endtask

    task automatic run_wraps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 3)) begin
                en         = 1'($urandom_range(0, 1));
                tone3_wrap = 1'b0;
                @(negedge clk);
            end
            en         = 1'($urandom_range(0, 1));
            tone3_wrap = 1'b1;
            m_wraps++;
            if (m_wraps % 2 == 1) push_shift();
            @(negedge clk);
        end
        en         = 1'b0;
        tone3_wrap = 1'b0;
    endtask

    task automatic settle_and_check(input string name, input logic [15:0] exp);
        @(negedge clk);
        #1;
        check_int({name, "_pending"}, sb.size(), 0);
        check16({name, "_lfsr"}, lfsr_state, exp);
        check16({name, "_out"}, {15'b0, out}, {15'b0, exp[0]});
        sb.delete();
    endtask

    // Scoreboard consumer: each strobe must match the oldest predicted shift.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (shift_strobe) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none, lfsr=%h", cyc, lfsr_state);
                end else begin
                    e = sb.pop_front();
                    check_int("strobe_cycle", cyc, e.edge_no);
                    check16("shift_lfsr", lfsr_state, e.lfsr);
                    check16("shift_out", {15'b0, out}, {15'b0, e.lfsr[0]});
                end
            end else if (sb.size() != 0 && sb[0].edge_no <= cyc) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_strobe: got no strobe expected one at cycle %0d (lfsr %h)", e.edge_no, e.lfsr);
            end
        end
    end

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{3'b000, 2'd0, 1,  1'b0, 16'h2000};
        vecs[1]  = '{3'b000, 2'd0, 14, 1'b0, 16'h0001};
        vecs[2]  = '{3'b000, 2'd0, 15, 1'b1, 16'h4000};
        vecs[3]  = '{3'b000, 2'd1, 15, 1'b0, 16'h0001};
        vecs[4]  = '{3'b000, 2'd1, 16, 1'b0, 16'h8000};
        vecs[5]  = '{3'b100, 2'd0, 14, 1'b0, 16'h4001};
        vecs[6]  = '{3'b100, 2'd0, 15, 1'b1, 16'h6000};
        vecs[7]  = '{3'b100, 2'd1, 13, 1'b0, 16'h8004};
        vecs[8]  = '{3'b100, 2'd2, 11, 1'b0, 16'h4008};
        vecs[9]  = '{3'b100, 2'd3, 14, 1'b0, 16'h4001};
        vecs[10] = '{3'b001, 2'd0, 3,  1'b1, 16'h0800};
        vecs[11] = '{3'b010, 2'd1, 2,  1'b0, 16'h2000};
        vecs[12] = '{3'b000, 2'd2, 5,  1'b0, 16'h0200};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            en         = 1'($urandom_range(0, 1));
            ctrl_we    = 1'($urandom_range(0, 1));
            ctrl       = 3'($urandom_range(0, 7));
            tap_mode   = 2'($urandom_range(0, 3));
            tone3_wrap = 1'($urandom_range(0, 1));
            #1;
            check16("reset_lfsr", lfsr_state, 16'h4000);
            check16("reset_out", {15'b0, out}, 16'h0000);
            check16("reset_strobe", {15'b0, shift_strobe}, 16'h0000);
        end
        @(negedge clk);
        en = 1'b0; ctrl_we = 1'b0; ctrl = 3'b000; tap_mode = 2'd0; tone3_wrap = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int unsigned v = 0; v < 13; v++) begin
            do_write(vecs[v].c, vecs[v].t);
            run_ticks((2 * vecs[v].shifts - 1) * n_of(vecs[v].c[1:0]), vecs[v].gaps);
            settle_and_check($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Tone3-clocked mode: 10 pulses -> 5 shifts, en toggling ignored
        do_write(3'b011, 2'd0);
        run_wraps(10);
        repeat (20) begin
            en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        en = 1'b0;
        settle_and_check("tone3", 16'h0200);

        // Write collides with a due shift (tick 48)
        do_write(3'b000, 2'd0);
        run_ticks(47, 1'b0);
        do_write(3'b000, 2'd1);
        #1;
        check16("collision_seed", lfsr_state, 16'h8000);
        check16("collision_strobe", {15'b0, shift_strobe}, 16'h0000);
        run_ticks(16, 1'b0);
        settle_and_check("collision_next", 16'h4000);

        // Asynchronous reset in the middle of a white-mode run
        do_write(3'b100, 2'd0);
        run_ticks(20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check16("midreset_lfsr", lfsr_state, 16'h4000);
        check16("midreset_out", {15'b0, out}, 16'h0000);
        check16("midreset_strobe", {15'b0, shift_strobe}, 16'h0000);
        check_int("midreset_pending", sb.size(), 0);
        sb.delete();
        m_lfsr = 16'h4000; m_fb = 1'b0; m_tap = 2'd0; m_n = 16; m_ticks = 0; m_wraps = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(16, 1'b0);
        settle_and_check("after_reset", 16'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
